// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: L2 line-side port and memory burst-side port of the cacheline adaptor
interface cacheline_adaptor_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BURST_WIDTH = 64
);
  logic line_read, line_write, line_resp;
  logic [31:0] line_address;
  logic [LINE_WIDTH-1:0] line_wdata, line_rdata;
  logic mem_read, mem_write, mem_resp;
  logic [31:0] mem_address;
  logic [BURST_WIDTH-1:0] mem_wdata, mem_rdata;
  modport master (
    output line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
    input line_rdata, line_resp, mem_read, mem_write, mem_address, mem_wdata
  );
  modport slave (
    input line_read, line_write, line_address, line_wdata, mem_rdata, mem_resp,
    output line_rdata, line_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: splits one cacheline into BEATS memory bursts and reassembles read bursts into a line
module cacheline_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BURST_WIDTH = 64,
  parameter int BEATS = 4
) (
  input logic clk,
  input logic rst,
  cacheline_adaptor_if.slave bus
);
  localparam int CW = $clog2(BEATS);
  localparam logic [31:0] ALIGN = 32'(LINE_WIDTH / 8 - 1);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, READ_DONE = 3'd2, WRITE = 3'd3, WRITE_DONE = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] count;
  logic [LINE_WIDTH-1:0] read_buf, wbuf;
  logic [31:0] addr;
  logic last;
  assign last = count == CW'(BEATS - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      read_buf <= '0;
      wbuf <= '0;
      addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          // read wins when both requests are raised together
          if (bus.line_read || bus.line_write) begin
            addr <= bus.line_address & ~ALIGN;
            count <= '0;
            state <= bus.line_read ? READ : WRITE;
          end
          if (!bus.line_read && bus.line_write) wbuf <= bus.line_wdata;
        end
        READ: if (bus.mem_resp) begin
          read_buf[count*BURST_WIDTH +: BURST_WIDTH] <= bus.mem_rdata;
          count <= count + CW'(1);
          if (last) state <= READ_DONE;
        end
        WRITE: if (bus.mem_resp) begin
          count <= count + CW'(1);
          if (last) state <= WRITE_DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.mem_read = state == READ;
  assign bus.mem_write = state == WRITE;
  assign bus.line_resp = state == READ_DONE || state == WRITE_DONE;
  assign bus.mem_address = addr;
  assign bus.line_rdata = read_buf;
  assign bus.mem_wdata = wbuf[count*BURST_WIDTH +: BURST_WIDTH];
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: randomized scoreboard bench with a behavioural memory model for cacheline_adaptor
module tb_cacheline_adaptor;
  localparam int LW = 256, BW = 64, NB = 4;
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [LW-1:0] line;
  } txn_t;
  logic clk = 0, rst = 0;
  cacheline_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus();
  cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .BEATS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  txn_t exp_q[$];
  logic [BW-1:0] rbeat_q[$], wbeat_q[$];
  int checks = 0, passes = 0, beats = 0, wait_cnt = 0, gap_mode = 0;
  bit exp_resp = 0;
  logic [LW-1:0] last_line = '0;

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, want);
  endtask

  // memory model and monitor: answers bursts, pops expectations whenever the DUT presents a beat or a response
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bus.mem_resp = 0;
        bus.mem_rdata = '0;
        beats = 0;
        exp_resp = 0;
        wait_cnt = 0;
        last_line = '0;
      end else begin
        chk("resp_timing", LW'(bus.line_resp), LW'(exp_resp));
        exp_resp = 0;
        if (bus.line_resp) begin
          chk("resp_bus_idle", LW'({bus.mem_read, bus.mem_write}), '0);
          beats = 0;
          wait_cnt = 0;
          chk("resp_expected", LW'(exp_q.size() != 0), LW'(1));
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            if (!t.wr) begin
              chk("line_rdata", bus.line_rdata, t.line);
              last_line = t.line;
            end
          end
        end else if (!bus.mem_read) chk("rdata_hold", bus.line_rdata, last_line);
        if (bus.mem_read || bus.mem_write) begin
          chk("busy_expected", LW'(exp_q.size() != 0), LW'(1));
          if (exp_q.size() != 0) begin
            chk("mem_address", LW'(bus.mem_address), LW'(exp_q[0].addr));
            chk("direction", LW'({bus.mem_read, bus.mem_write}), LW'({!exp_q[0].wr, exp_q[0].wr}));
          end
          if (wait_cnt > 0) begin
            wait_cnt--;
            bus.mem_resp = 0;
          end else begin
            bus.mem_resp = 1;
            if (bus.mem_write) begin
              chk("wbeat_expected", LW'(wbeat_q.size() != 0), LW'(1));
              if (wbeat_q.size() != 0) chk("mem_wdata", LW'(bus.mem_wdata), LW'(wbeat_q.pop_front()));
            end else bus.mem_rdata = rbeat_q.size() != 0 ? rbeat_q.pop_front() : '0;
            beats++;
            exp_resp = beats == NB;
            wait_cnt = gap_mode == 2 ? 2 : gap_mode == 1 ? 0 : int'($urandom_range(0, 2));
          end
        end else begin
          bus.mem_resp = $urandom_range(0, 3) == 0;
          bus.mem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  task automatic run_txn(bit wr, logic [31:0] a, logic [LW-1:0] line, bit churn, bit both, int lead);
    txn_t t;
    int n;
    t.wr = wr;
    t.addr = a - (a % 32);
    t.line = line;
    exp_q.push_back(t);
    for (int k = 0; k < NB; k++)
      if (wr) wbeat_q.push_back(line[k*BW +: BW]);
      else rbeat_q.push_back(line[k*BW +: BW]);
    bus.line_address = a;
    bus.line_wdata = wr ? line : {8{$urandom}};
    bus.line_read = !wr;
    bus.line_write = wr || both;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.line_resp) break;
      chk("busy", LW'(bus.mem_read || bus.mem_write), LW'(n >= lead));
      if (n >= lead && churn) begin
        bus.line_address = $urandom;
        bus.line_wdata = {8{$urandom}};
        if (wr) bus.line_read = 1'($urandom_range(0, 1));
        else bus.line_write = 1'($urandom_range(0, 1));
      end
    end
    chk("no_timeout", LW'(n < 200), LW'(1));
    bus.line_read = 0;
    bus.line_write = 0;
  endtask

  task automatic reset_mid_burst();
    txn_t t;
    int n;
    t.wr = 0;
    t.addr = 32'h0000_4000;
    t.line = {8{$urandom}};
    exp_q.push_back(t);
    for (int k = 0; k < NB; k++) rbeat_q.push_back(t.line[k*BW +: BW]);
    bus.line_address = 32'h0000_4010;
    bus.line_read = 1;
    for (n = 0; n < 50 && beats < 2; n++) begin
      @(negedge clk);
      #1;
    end
    chk("two_beats_reached", LW'(beats == 2), LW'(1));
    @(posedge clk);
    #1 rst = 0;
    #1;
    chk("midrst_line_rdata", bus.line_rdata, '0);
    chk("midrst_ctrl", LW'({bus.line_resp, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata}), '0);
    bus.line_read = 0;
    exp_q.delete();
    rbeat_q.delete();
    wbeat_q.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1;
  endtask

  initial begin
    bus.line_read = 0;
    bus.line_write = 0;
    bus.line_address = '0;
    bus.line_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_line_rdata", bus.line_rdata, '0);
    chk("reset_ctrl", LW'({bus.line_resp, bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata}), '0);
    #1 rst = 1;
    repeat (2) @(negedge clk);
    gap_mode = 1;
    run_txn(0, 32'h0000_1234, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 0, 0, 0);
    repeat (2) @(negedge clk);
    run_txn(1, $urandom, 256'h0123456789abcdef_fedcba9876543210_0011223344556677_8899aabbccddeeff, 0, 0, 0);
    repeat (2) @(negedge clk);
    gap_mode = 2;
    run_txn(0, $urandom, {8{$urandom}}, 0, 0, 0);
    repeat (2) @(negedge clk);
    gap_mode = 0;
    run_txn(1, $urandom, {8{$urandom}}, 1, 0, 0);
    repeat (2) @(negedge clk);
    run_txn(0, $urandom, {8{$urandom}}, 0, 1, 0);
    repeat (2) @(negedge clk);
    gap_mode = 1;
    reset_mid_burst();
    @(negedge clk);
    run_txn(0, $urandom, {8{$urandom}}, 0, 0, 0);
    @(negedge clk);
    run_txn(0, $urandom, {8{$urandom}}, 0, 0, 0);
    run_txn(1, $urandom, {8{$urandom}}, 0, 0, 1);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      gap_mode = int'($urandom_range(0, 2));
      run_txn(1'($urandom_range(0, 1)), $urandom, {8{$urandom}}, 1'($urandom_range(0, 1)), 0, 0);
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
